// File: rtl/apb_reg_block_pkg.sv
// Shared constants for the APB register block: offsets, status bits,
// RX read-strobe encodings and default FIFO sizing.
package apb_reg_block_pkg;

  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [4:0] OFF_TX     = 5'd0;
  localparam logic [4:0] OFF_CR     = 5'd4;
  localparam logic [4:0] OFF_ADDR   = 5'd8;
  localparam logic [4:0] OFF_DIV    = 5'd12;
  localparam logic [4:0] OFF_RX     = 5'd16;
  localparam logic [4:0] OFF_STATUS = 5'd20;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_RX_UNF   = 6;
  localparam int ST_DONE     = 7;
  localparam int ST_NACK     = 8;

  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_HOLD = 2'b10,
    RX_POP  = 2'b11
  } rx_op_e;

  function automatic logic is_reg_offset(
    input logic [4:0] a
  );
    return (a == OFF_TX) || (a == OFF_CR) ||
           (a == OFF_ADDR) || (a == OFF_DIV) ||
           (a == OFF_RX) || (a == OFF_STATUS);
  endfunction

endpackage

// File: rtl/apb_reg_block_sync_fifo.sv
// Single-clock FIFO; push and pop in one cycle both take effect,
// even when full. Pop on empty is ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     pclk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_reg_block.sv
// APB-side register block: control/addr/divider registers, TX/RX FIFOs,
// sticky status flags and the registered read-data path.
module apb_reg_block
  import apb_reg_block_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATA_W     = 8
) (
  input  logic              pclk,
  input  logic              n_rst,
  input  logic [31:0]       pwdata,
  input  logic              tx_w_ena,
  input  logic              cr_w_ena,
  input  logic              cr_r_ena,
  input  logic              addr_ena,
  input  logic              clk_div_ena,
  input  logic              status_clear,
  input  logic [1:0]        rx_r_ena,
  output logic [31:0]       prdata,
  output logic [7:0]        control,
  output logic [7:0]        addr_reg,
  output logic [15:0]       clk_div,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_empty,
  input  logic              tx_pop,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_push,
  output logic              rx_full,
  input  logic              xfer_done,
  input  logic              nack
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              tx_full;
  logic              rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [CW-1:0]     tx_count;
  logic [CW-1:0]     rx_count;
  logic              rx_rd;
  logic              rx_pop_eff;
  logic [4:0]        sticky;
  logic [4:0]        sticky_set;
  logic [31:0]       status;
  logic              unused;

  // status_clear owns prdata, so it also blocks a same-cycle RX pop
  assign rx_rd      = (rx_r_ena == RX_POP) & ~status_clear;
  assign rx_pop_eff = rx_rd & ~rx_empty;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx (
    .pclk  (pclk),
    .n_rst (n_rst),
    .push  (tx_w_ena),
    .pop   (tx_pop),
    .din   (pwdata[DATA_W-1:0]),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx (
    .pclk  (pclk),
    .n_rst (n_rst),
    .push  (rx_push),
    .pop   (rx_rd),
    .din   (rx_data_in),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign sticky_set = {
    nack,
    xfer_done,
    rx_rd & rx_empty,
    rx_push & rx_full & ~rx_pop_eff,
    tx_w_ena & tx_full & ~tx_pop
  };

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_OVF]   = sticky[0];
    status[ST_RX_OVF]   = sticky[1];
    status[ST_RX_UNF]   = sticky[2];
    status[ST_DONE]     = sticky[3];
    status[ST_NACK]     = sticky[4];
  end

  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      prdata   <= '0;
      control  <= '0;
      addr_reg <= '0;
      clk_div  <= '0;
      sticky   <= '0;
    end else begin
      if (cr_w_ena)    control  <= pwdata[7:0];
      if (addr_ena)    addr_reg <= pwdata[7:0];
      if (clk_div_ena) clk_div  <= pwdata[15:0];
      // a set event in the clearing cycle survives the clear
      sticky <= (sticky & {5{~status_clear}}) | sticky_set;
      if (status_clear)  prdata <= status;
      else if (rx_rd)    prdata <= 32'(rx_head);
      else if (cr_r_ena) prdata <= {24'b0, control};
    end
  end

  assign unused = ^{pwdata[31:16], tx_count, rx_count};

endmodule

// File: doc/apb_reg_block.md
APB_REG_BLOCK -- requirements
Module: apb_reg_block

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per TX/RX FIFO (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 8, FIFO data width.
REQ-003 pclk  in  1  clock; all state updates on rising edge.
REQ-004 n_rst  in  1  reset, asynchronous, active-low.
REQ-005 pwdata  in  32  APB write data.
REQ-006 tx_w_ena, cr_w_ena, cr_r_ena, addr_ena, clk_div_ena, status_clear  in  1 each  decoded single-cycle access strobes.
REQ-007 rx_r_ena  in  2  11=pop RX and capture, 10=hold read data, 00=idle.
REQ-008 prdata  out  32  registered APB read data.
REQ-009 control  out  8  control register; addr_reg  out  8  target address; clk_div  out  16  clock divider.
REQ-010 tx_data  out  DATA_W  TX FIFO head; tx_empty  out  1; tx_pop  in  1  core consumes head.
REQ-011 rx_data_in  in  DATA_W; rx_push  in  1  core writes received byte; rx_full  out  1.
REQ-012 xfer_done, nack  in  1 each  core event pulses.

Function
REQ-013 tx_w_ena SHALL push pwdata[DATA_W-1:0] into TX FIFO; push while full and no tx_pop in that cycle SHALL drop data and set sticky tx_ovf.
REQ-014 tx_pop on empty TX FIFO SHALL be ignored; push+pop same cycle SHALL both occur, count unchanged, no overflow even when full.
REQ-015 cr_w_ena SHALL load control <= pwdata[7:0]; addr_ena SHALL load addr_reg <= pwdata[7:0]; clk_div_ena SHALL load clk_div <= pwdata[15:0]; all visible the next cycle.
REQ-016 cr_r_ena SHALL load prdata <= {24'b0, control}.
REQ-017 rx_r_ena==11 with RX non-empty SHALL load prdata <= zero-extended head and pop one entry; with RX empty SHALL load prdata <= 0 and set sticky rx_unf.
REQ-018 rx_r_ena==10 or 00 SHALL leave prdata and RX FIFO unchanged.
REQ-019 rx_push while RX full and no pop that cycle SHALL drop data and set sticky rx_ovf; push+pop same cycle SHALL both occur.
REQ-020 status vector: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full (live), [4] tx_ovf, [5] rx_ovf, [6] rx_unf, [7] done, [8] nack (sticky), [31:9] 0.
REQ-021 status_clear SHALL load prdata <= status vector (pre-clear value) and clear sticky bits [8:4] in same edge.
REQ-022 Sticky set event coincident with status_clear SHALL win (bit remains 1).
REQ-023 xfer_done SHALL set done; nack SHALL set nack sticky.
REQ-024 Strobes are mutually exclusive by construction; if more than one read strobe asserts, priority SHALL be status_clear > rx_r_ena==11 > cr_r_ena.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-026 prdata SHALL hold its value between read strobes.

Reset
REQ-027 n_rst low SHALL asynchronously clear prdata, control, addr_reg, clk_div, all sticky bits, FIFO pointers and counts; tx_empty=1, rx_full=0, tx_data=0.
REQ-028 Reset mid-access SHALL discard in-flight push/pop; first post-reset strobe SHALL behave as from empty.

Structure
REQ-029 Shared package SHALL hold register offsets (0,4,8,12,16,20), status bit indices, rx_r_ena encodings, default FIFO_DEPTH.
REQ-030 One sub-module sync_fifo (params DEPTH, WIDTH; push/pop/full/empty/head/count) SHALL be instantiated twice (TX, RX); overflow/underflow flags live in apb_reg_block.

Verification
REQ-031 Reset, then cr_w_ena with pwdata=0x000000A5, then cr_r_ena -> control=0xA5, prdata=0x000000A5.
REQ-032 Five tx_w_ena writes 0x11..0x55, no tx_pop -> tx_data=0x11, status[1]=1, status[4]=1; four tx_pop -> 0x11,0x22,0x33,0x44, then tx_empty=1.
REQ-033 rx_push 0x3C then rx_r_ena 11 then 10 for 3 cycles -> prdata=0x3C held, rx_empty=1; next rx_r_ena 11 -> prdata=0, rx_unf=1.
REQ-034 Full RX FIFO, rx_push and rx_r_ena 11 same cycle -> count stays 4, rx_ovf=0, prdata=oldest entry.
REQ-035 nack pulse coincident with status_clear -> prdata shows prior status, nack bit still 1 afterwards; second status_clear -> bit 8 cleared.
REQ-036 clk_div_ena with pwdata=0xFFFF1234, n_rst pulsed low next cycle -> clk_div=0x1234 then 0x0000 asynchronously.
